// File: rtl/flash_bus_arbiter_pkg.sv
// Shared definitions for the flash bus arbiter: FSM state codes, arbitration
// mode codes and small index helpers.
package flash_bus_arbiter_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_BUSY = 2'd1;
   localparam state_t ST_RESP = 2'd2;

   localparam int PRIO_RR    = 0;
   localparam int PRIO_FIXED = 1;

   localparam int WSTRB_W = 4;

   // Next round-robin position after idx, wrapping at n.
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      int unsigned nxt;
      nxt = idx + 32'd1;
      return (nxt >= n) ? 32'd0 : nxt;
   endfunction

endpackage

// File: rtl/flash_bus_arbiter_if.sv
// Bundles the requester-side slices and the single controller port of the
// flash bus arbiter. The arbiter uses the slave view, the environment the master view.
interface flash_bus_arbiter_if #(
   parameter int N_REQ  = 2,
   parameter int ADDR_W = 15,
   parameter int DATA_W = 32
);
   logic [N_REQ-1:0]        req_select;
   logic [4*N_REQ-1:0]      req_wstrb;
   logic [ADDR_W*N_REQ-1:0] req_addr;
   logic [DATA_W*N_REQ-1:0] req_wdata;
   logic [N_REQ-1:0]        req_ready;
   logic [DATA_W-1:0]       req_rdata;

   logic                    mem_select;
   logic [3:0]              mem_wstrb;
   logic [ADDR_W-1:0]       mem_addr;
   logic [DATA_W-1:0]       mem_data_i;
   logic                    mem_ready;
   logic [DATA_W-1:0]       mem_data_o;

   logic [N_REQ-1:0]        grant;
   logic                    busy;

   modport slave (
      input  req_select, req_wstrb, req_addr, req_wdata, mem_ready, mem_data_o,
      output req_ready, req_rdata, mem_select, mem_wstrb, mem_addr, mem_data_i,
             grant, busy
   );

   modport master (
      output req_select, req_wstrb, req_addr, req_wdata, mem_ready, mem_data_o,
      input  req_ready, req_rdata, mem_select, mem_wstrb, mem_addr, mem_data_i,
             grant, busy
   );

endinterface

// File: rtl/flash_bus_arbiter_rr_pick.sv
// One-hot winner selection: scan req starting at ptr upward with wrap and
// return the first set bit. ptr = 0 gives plain lowest-index priority.
module rr_pick #(
   parameter int N     = 2,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     winner
);

   logic found_s;
   int   idx_s;

   // Rotated find-first-set; the modulo index performs the rotate and rotate-back.
   always_comb begin
      winner  = {N{1'b0}};
      found_s = 1'b0;
      idx_s   = 0;
      for (int i = 0; i < N; i++) begin
         idx_s         = (i + int'(ptr)) % N;
         winner[idx_s] = req[idx_s] & ~found_s;
         found_s       = found_s | req[idx_s];
      end
   end

endmodule

// File: rtl/flash_bus_arbiter.sv
// Shares one flash cache controller port between N_REQ requesters, one
// registered transaction at a time, in round-robin or fixed-priority order.
module flash_bus_arbiter
   import flash_bus_arbiter_pkg::*;
#(
   parameter int N_REQ     = 2,
   parameter int ADDR_W    = 15,
   parameter int DATA_W    = 32,
   parameter int PRIO_MODE = 0
) (
   input  logic                clk,
   input  logic                reset_n,
   flash_bus_arbiter_if.slave  bus
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_t              state_r;
   logic [PTR_W-1:0]    rr_ptr_r;
   logic [PTR_W-1:0]    win_idx_r;
   logic [N_REQ-1:0]    grant_r;
   logic [N_REQ-1:0]    req_ready_r;
   logic [DATA_W-1:0]   req_rdata_r;
   logic                mem_select_r;
   logic [WSTRB_W-1:0]  mem_wstrb_r;
   logic [ADDR_W-1:0]   mem_addr_r;
   logic [DATA_W-1:0]   mem_data_i_r;
   logic                busy_r;

   logic [PTR_W-1:0]    pick_ptr_s;
   logic [N_REQ-1:0]    win_s;
   logic [PTR_W-1:0]    win_idx_s;
   logic [WSTRB_W-1:0]  sel_wstrb_s;
   logic [ADDR_W-1:0]   sel_addr_s;
   logic [DATA_W-1:0]   sel_wdata_s;

   // Fixed priority is the round-robin picker with the pointer parked at 0.
   assign pick_ptr_s = (PRIO_MODE == PRIO_FIXED) ? {PTR_W{1'b0}} : rr_ptr_r;

   rr_pick #(
      .N     (N_REQ),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .req    (bus.req_select),
      .ptr    (pick_ptr_s),
      .winner (win_s)
   );

   // AND-OR mux of the winning requester's slice and its index.
   always_comb begin
      sel_wstrb_s = {WSTRB_W{1'b0}};
      sel_addr_s  = {ADDR_W{1'b0}};
      sel_wdata_s = {DATA_W{1'b0}};
      win_idx_s   = {PTR_W{1'b0}};
      for (int i = 0; i < N_REQ; i++) begin
         sel_wstrb_s = sel_wstrb_s | (bus.req_wstrb[WSTRB_W*i +: WSTRB_W] & {WSTRB_W{win_s[i]}});
         sel_addr_s  = sel_addr_s  | (bus.req_addr[ADDR_W*i +: ADDR_W]    & {ADDR_W{win_s[i]}});
         sel_wdata_s = sel_wdata_s | (bus.req_wdata[DATA_W*i +: DATA_W]   & {DATA_W{win_s[i]}});
         win_idx_s   = win_idx_s   | (win_s[i] ? PTR_W'(i) : {PTR_W{1'b0}});
      end
   end

   // Transaction sequencing: arbitrate in IDLE, hold in BUSY, pulse ready in RESP.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= ST_IDLE;
         rr_ptr_r     <= {PTR_W{1'b0}};
         win_idx_r    <= {PTR_W{1'b0}};
         grant_r      <= {N_REQ{1'b0}};
         req_ready_r  <= {N_REQ{1'b0}};
         req_rdata_r  <= {DATA_W{1'b0}};
         mem_select_r <= 1'b0;
         mem_wstrb_r  <= {WSTRB_W{1'b0}};
         mem_addr_r   <= {ADDR_W{1'b0}};
         mem_data_i_r <= {DATA_W{1'b0}};
         busy_r       <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (|bus.req_select) begin
                  mem_wstrb_r  <= sel_wstrb_s;
                  mem_addr_r   <= sel_addr_s;
                  mem_data_i_r <= sel_wdata_s;
                  win_idx_r    <= win_idx_s;
                  grant_r      <= win_s;
                  mem_select_r <= 1'b1;
                  busy_r       <= 1'b1;
                  state_r      <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               // Select drops with the done pulse so the controller idles with select low.
               if (bus.mem_ready) begin
                  mem_select_r <= 1'b0;
                  req_rdata_r  <= bus.mem_data_o;
                  req_ready_r  <= grant_r;
                  rr_ptr_r     <= PTR_W'(wrap_inc(32'(win_idx_r), N_REQ));
                  state_r      <= ST_RESP;
               end
            end
            ST_RESP: begin
               req_ready_r <= {N_REQ{1'b0}};
               grant_r     <= {N_REQ{1'b0}};
               busy_r      <= 1'b0;
               state_r     <= ST_IDLE;
            end
            default: begin
               mem_select_r <= 1'b0;
               req_ready_r  <= {N_REQ{1'b0}};
               grant_r      <= {N_REQ{1'b0}};
               busy_r       <= 1'b0;
               state_r      <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready  = req_ready_r;
   assign bus.req_rdata  = req_rdata_r;
   assign bus.mem_select = mem_select_r;
   assign bus.mem_wstrb  = mem_wstrb_r;
   assign bus.mem_addr   = mem_addr_r;
   assign bus.mem_data_i = mem_data_i_r;
   assign bus.grant      = grant_r;
   assign bus.busy       = busy_r;

endmodule

// File: tb/tb_flash_bus_arbiter.sv
// Randomized and directed bench for flash_bus_arbiter: a round-robin and a
// fixed-priority instance run side by side against a transaction-level model.
module tb_flash_bus_arbiter;

   localparam int N  = 2;
   localparam int AW = 15;
   localparam int DW = 32;
   localparam int ND = 2;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]    sel_v   [ND];
   logic [4*N-1:0]  wstrb_v [ND];
   logic [AW*N-1:0] addr_v  [ND];
   logic [DW*N-1:0] wdata_v [ND];
   logic            mrdy_v  [ND];
   logic [DW-1:0]   mdo_v   [ND];

   logic [N-1:0]    rdy_o    [ND];
   logic [N-1:0]    gnt_o    [ND];
   logic [DW-1:0]   rdata_o  [ND];
   logic [DW-1:0]   mdi_o    [ND];
   logic            msel_o   [ND];
   logic            busy_o   [ND];
   logic [3:0]      mwstrb_o [ND];
   logic [AW-1:0]   maddr_o  [ND];

   for (genvar g = 0; g < ND; g++) begin : g_dut
      flash_bus_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
      assign bus.req_select = sel_v[g];
      assign bus.req_wstrb  = wstrb_v[g];
      assign bus.req_addr   = addr_v[g];
      assign bus.req_wdata  = wdata_v[g];
      assign bus.mem_ready  = mrdy_v[g];
      assign bus.mem_data_o = mdo_v[g];
      assign rdy_o[g]    = bus.req_ready;
      assign gnt_o[g]    = bus.grant;
      assign rdata_o[g]  = bus.req_rdata;
      assign mdi_o[g]    = bus.mem_data_i;
      assign msel_o[g]   = bus.mem_select;
      assign busy_o[g]   = bus.busy;
      assign mwstrb_o[g] = bus.mem_wstrb;
      assign maddr_o[g]  = bus.mem_addr;
      flash_bus_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(g)) u_dut (
         .clk     (clk),
         .reset_n (reset_n),
         .bus     (bus)
      );
   end

   string dn [ND] = '{"rr", "fp"};
   int n_checks = 0;
   int n_fail   = 0;

   // transaction-level model
   int            m_owner [ND];
   logic          m_msel  [ND];
   logic [N-1:0]  m_rdy   [ND];
   logic [DW-1:0] m_rdata [ND];
   logic [DW-1:0] m_wdata [ND];
   logic [3:0]    m_wstrb [ND];
   logic [AW-1:0] m_addr  [ND];
   int            m_ptr   [ND];

   // environment: controller and requesters
   logic          ctl_busy  [ND];
   int            ctl_wait  [ND];
   int            force_lat [ND];
   logic [DW-1:0] ctl_last  [ND];
   int            reissue_n [ND][N];
   bit            rnd_on = 1'b0;
   int            pend_cnt [N];
   int            max_wait = 0;
   logic [N-1:0]  done_q0 [$];
   logic [N-1:0]  done_q1 [$];

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] qat(input int d, input int k);
      if (d == 0) return (done_q0.size() > k) ? done_q0[k] : {N{1'bx}};
      else        return (done_q1.size() > k) ? done_q1[k] : {N{1'bx}};
   endfunction

   function automatic int qsize(input int d);
      return (d == 0) ? done_q0.size() : done_q1.size();
   endfunction

   task automatic qclr();
      done_q0.delete();
      done_q1.delete();
   endtask

   task automatic env_reset();
      for (int d = 0; d < ND; d++) begin
         m_owner[d] = -1;  m_msel[d] = 1'b0; m_rdy[d] = '0; m_rdata[d] = '0;
         m_wdata[d] = '0;  m_wstrb[d] = '0;  m_addr[d] = '0; m_ptr[d] = 0;
         sel_v[d] = '0; wstrb_v[d] = '0; addr_v[d] = '0; wdata_v[d] = '0;
         mrdy_v[d] = 1'b0; mdo_v[d] = '0; ctl_busy[d] = 1'b0; ctl_wait[d] = 0;
         for (int i = 0; i < N; i++) reissue_n[d][i] = 0;
      end
      for (int i = 0; i < N; i++) pend_cnt[i] = 0;
   endtask

   task automatic new_req(input int d, input int i);
      sel_v[d][i] = 1'b1;
      addr_v[d][AW*i +: AW]  = AW'($urandom);
      wstrb_v[d][4*i +: 4]   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      wdata_v[d][DW*i +: DW] = $urandom;
   endtask

   // One clock edge of the arbiter's rules applied to the transaction model.
   task automatic model_edge(input int d);
      int w;
      int start;
      if (m_rdy[d] != '0) begin
         m_rdy[d]   = '0;
         m_owner[d] = -1;
      end else if (m_owner[d] < 0) begin
         if (sel_v[d] != '0) begin
            w     = -1;
            start = (d == 1) ? 0 : m_ptr[d];
            for (int k = 0; k < N; k++) begin
               if (w < 0 && sel_v[d][(start + k) % N]) w = (start + k) % N;
            end
            m_owner[d] = w;
            m_msel[d]  = 1'b1;
            m_addr[d]  = addr_v[d][AW*w +: AW];
            m_wstrb[d] = wstrb_v[d][4*w +: 4];
            m_wdata[d] = wdata_v[d][DW*w +: DW];
         end
      end else if (m_msel[d] && mrdy_v[d]) begin
         m_msel[d]  = 1'b0;
         m_rdata[d] = mdo_v[d];
         m_rdy[d]   = N'(1) << m_owner[d];
         m_ptr[d]   = (m_owner[d] + 1) % N;
      end
   endtask

   task automatic step();
      logic [N-1:0] eg;
      @(posedge clk);
      if (reset_n) for (int d = 0; d < ND; d++) model_edge(d);
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
         eg = (m_owner[d] >= 0) ? (N'(1) << m_owner[d]) : {N{1'b0}};
         check_eq({dn[d], ".grant"}, gnt_o[d], eg);
         check_eq({dn[d], ".busy"},  busy_o[d], m_owner[d] >= 0);
         check_eq({dn[d], ".msel"},  msel_o[d], m_msel[d]);
         check_eq({dn[d], ".ready"}, rdy_o[d], m_rdy[d]);
         check_eq({dn[d], ".rdata"}, rdata_o[d], m_rdata[d]);
         check_eq({dn[d], ".addr"},  maddr_o[d], m_addr[d]);
         check_eq({dn[d], ".wstrb"}, mwstrb_o[d], m_wstrb[d]);
         check_eq({dn[d], ".wdata"}, mdi_o[d], m_wdata[d]);
         if (rdy_o[d] != '0) begin
            if (d == 0) done_q0.push_back(rdy_o[d]);
            else        done_q1.push_back(rdy_o[d]);
         end
         if (reset_n) begin
            if (d == 0 && m_rdy[0] != '0) begin
               for (int i = 0; i < N; i++) begin
                  if (m_rdy[0][i]) begin
                     if (pend_cnt[i] > max_wait) max_wait = pend_cnt[i];
                     pend_cnt[i] = 0;
                  end else if (sel_v[0][i]) begin
                     pend_cnt[i]++;
                  end
               end
            end
            // flash controller: fixed or random load time, garbage data when not ready
            mdo_v[d] = $urandom;
            if (mrdy_v[d]) begin
               mrdy_v[d]   = 1'b0;
               ctl_busy[d] = 1'b0;
            end else if (msel_o[d] && !ctl_busy[d]) begin
               ctl_busy[d] = 1'b1;
               ctl_wait[d] = (force_lat[d] > 0) ? force_lat[d]
                           : 1 + (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0);
            end
            if (ctl_busy[d] && !mrdy_v[d]) begin
               if (ctl_wait[d] == 0) begin
                  mrdy_v[d]   = 1'b1;
                  ctl_last[d] = mdo_v[d];
               end else begin
                  ctl_wait[d]--;
               end
            end
            for (int i = 0; i < N; i++) begin
               if (m_rdy[d][i]) begin
                  if (reissue_n[d][i] > 0) begin
                     reissue_n[d][i]--;
                     new_req(d, i);
                  end else if (rnd_on && $urandom_range(0, 99) < 30) begin
                     new_req(d, i);
                  end else begin
                     sel_v[d][i] = 1'b0;
                  end
               end else if (!sel_v[d][i] && rnd_on && $urandom_range(0, 99) < 20) begin
                  new_req(d, i);
               end
            end
         end
      end
   endtask

   function automatic bit all_idle();
      for (int d = 0; d < ND; d++) if (sel_v[d] != '0 || m_owner[d] >= 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic drain(input int limit);
      int k = 0;
      while (!all_idle() && k < limit) begin
         step();
         k++;
      end
      check_eq("drain", all_idle(), 1'b1);
   endtask

   initial begin
      int cnt;
      logic [AW-1:0] held_addr;
      logic [DW-1:0] wd;
      env_reset();
      force_lat[0] = 1;
      force_lat[1] = 1;
      #1 reset_n = 1'b0;
      repeat (3) step();
      check_eq("rst.msel", msel_o[0], 1'b0);
      check_eq("rst.grant", gnt_o[1], 2'b00);
      reset_n = 1'b1;
      step();

      // simultaneous requests after reset: req0 then req1, pointer back at 0
      qclr();
      for (int d = 0; d < ND; d++) begin new_req(d, 0); new_req(d, 1); end
      step();
      check_eq("t2.first", gnt_o[0], 2'b01);
      drain(50);
      check_eq("t2.seq0", qat(0, 0), 2'b01);
      check_eq("t2.seq1", qat(0, 1), 2'b10);
      new_req(0, 0); new_req(0, 1);
      step();
      check_eq("t2.ptr0", gnt_o[0], 2'b01);
      drain(50);

      // lone read from req0 with a cache hit
      qclr();
      for (int d = 0; d < ND; d++) begin
         new_req(d, 0);
         addr_v[d][AW-1:0]  = 15'h0012;
         wstrb_v[d][3:0]    = 4'h0;
      end
      cnt = 0;
      while (rdy_o[0] != 2'b01 && cnt < 20) begin step(); cnt++; end
      check_eq("t1.lat", cnt, 3);
      check_eq("t1.rdata", rdata_o[0], ctl_last[0]);
      check_eq("t1.addr", maddr_o[1], 15'h0012);
      drain(50);

      // full-strobe write from req0
      qclr();
      for (int d = 0; d < ND; d++) begin
         new_req(d, 0);
         wstrb_v[d][3:0] = 4'hF;
      end
      wd = wdata_v[0][DW-1:0];
      step();
      check_eq("t5.wstrb", mwstrb_o[0], 4'hF);
      check_eq("t5.wdata", mdi_o[0], wd);
      drain(50);
      check_eq("t5.ready", qat(0, 0), 2'b01);

      // long miss on req1, req0 arrives mid-way
      qclr();
      force_lat[0] = 70;
      new_req(0, 1);
      held_addr = addr_v[0][AW +: AW];
      repeat (30) step();
      new_req(0, 0);
      repeat (10) step();
      check_eq("t4.grant", gnt_o[0], 2'b10);
      check_eq("t4.addr", maddr_o[0], held_addr);
      drain(250);
      check_eq("t4.seq0", qat(0, 0), 2'b10);
      check_eq("t4.seq1", qat(0, 1), 2'b01);
      force_lat[0] = 1;

      // fixed priority: req0 re-requests and starves req1 once
      qclr();
      reissue_n[1][0] = 1;
      new_req(1, 0); new_req(1, 1);
      drain(60);
      check_eq("t3.seq0", qat(1, 0), 2'b01);
      check_eq("t3.seq1", qat(1, 1), 2'b01);
      check_eq("t3.seq2", qat(1, 2), 2'b10);

      // asynchronous reset in the middle of a transaction
      qclr();
      force_lat[0] = 20;
      force_lat[1] = 20;
      for (int d = 0; d < ND; d++) new_req(d, 0);
      repeat (3) step();
      #2 reset_n = 1'b0;
      #1;
      for (int d = 0; d < ND; d++) begin
         check_eq({dn[d], ".t6.msel"},  msel_o[d], 1'b0);
         check_eq({dn[d], ".t6.grant"}, gnt_o[d], 2'b00);
         check_eq({dn[d], ".t6.busy"},  busy_o[d], 1'b0);
         check_eq({dn[d], ".t6.addr"},  maddr_o[d], 15'h0000);
      end
      env_reset();
      repeat (2) step();
      reset_n = 1'b1;
      force_lat[0] = 1;
      force_lat[1] = 1;
      repeat (10) step();
      check_eq("t6.stray", qsize(0) + qsize(1), 0);
      for (int d = 0; d < ND; d++) new_req(d, 1);
      drain(50);
      check_eq("t6.post0", qat(0, 0), 2'b10);
      check_eq("t6.post1", qat(1, 0), 2'b10);

      // randomized traffic with random controller load times
      force_lat[0] = 0;
      force_lat[1] = 0;
      rnd_on = 1'b1;
      repeat (1500) step();
      rnd_on = 1'b0;
      drain(400);
      check_eq("rr.fair", max_wait <= N - 1, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
